// File: rtl/pipe_alu.sv
// Pipelined ALU: operands captured into stage 1, result/zero computed once and shifted to the output stage.
// Latency DEPTH cycles; one beat per cycle when unstalled. Optional carry/overflow outputs under PIPE_ALU_FLAGS_EN.
// Backpressure: a stalled output holds; each stage refills when empty or draining, in_ready is combinational from out_ready.
module pipe_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef PIPE_ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam int S = $clog2(WIDTH);

  logic [S-1:0]     sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] alu;
  logic             alu_zero;

  logic [DEPTH:1]   v;
  logic [DEPTH:1]   z;
  logic [WIDTH-1:0] r [1:DEPTH];
  logic [DEPTH:1]   rdy;
  logic             acc;

`ifdef PIPE_ALU_FLAGS_EN
  logic           cy_add;
  logic           cy_sub;
  logic           c_nxt;
  logic           o_nxt;
  logic [DEPTH:1] cf;
  logic [DEPTH:1] of;
`endif

  always_comb begin
    sh = b[S-1:0];
`ifdef PIPE_ALU_FLAGS_EN
    {cy_add, sum} = {1'b0, a} + {1'b0, b};
    {cy_sub, dif} = {1'b0, a} - {1'b0, b};
`else
    sum = a + b;
    dif = a - b;
`endif
    case (op)
      3'b000:  alu = sum;
      3'b001:  alu = dif;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      3'b101:  alu = a << sh;
      3'b110:  alu = a >> sh;
      default: alu = b;
    endcase
    alu_zero = (alu == '0);
  end

`ifdef PIPE_ALU_FLAGS_EN
  // Subtract carry is the borrow, i.e. a < b unsigned.
  always_comb begin
    c_nxt = 1'b0;
    o_nxt = 1'b0;
    if (op == 3'b000) begin
      c_nxt = cy_add;
      o_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == 3'b001) begin
      c_nxt = cy_sub;
      o_nxt = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

  // rdy[k]: stage k may load this cycle (empty, or everything downstream can move).
  always_comb begin
    rdy = '0;
    acc = out_ready;
    for (int k = DEPTH; k >= 1; k--) begin
      acc    = acc || !v[k];
      rdy[k] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      z <= '0;
      for (int k = 1; k <= DEPTH; k++) r[k] <= '0;
`ifdef PIPE_ALU_FLAGS_EN
      cf <= '0;
      of <= '0;
`endif
    end else begin
      if (rdy[1]) begin
        v[1] <= in_valid;
        if (in_valid) begin
          r[1] <= alu;
          z[1] <= alu_zero;
`ifdef PIPE_ALU_FLAGS_EN
          cf[1] <= c_nxt;
          of[1] <= o_nxt;
`endif
        end
      end
      for (int k = 2; k <= DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            r[k] <= r[k-1];
            z[k] <= z[k-1];
`ifdef PIPE_ALU_FLAGS_EN
            cf[k] <= cf[k-1];
            of[k] <= of[k-1];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = v[DEPTH];
  assign result    = r[DEPTH];
  assign zero      = z[DEPTH];
`ifdef PIPE_ALU_FLAGS_EN
  assign carry     = cf[DEPTH];
  assign overflow  = of[DEPTH];
`endif

endmodule

// File: tb/tb_pipe_alu.sv
// Bench for pipe_alu: three instances (DEPTH 1, 2, 4) checked through per-instance scoreboards.
// Flag outputs are connected and checked only when PIPE_ALU_FLAGS_EN is defined.
module tb_pipe_alu;
  localparam int W = 8;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    int         acc;
    bit         lat;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         iv [3];
  logic         ir [3];
  logic         ovl [3];
  logic         orr [3];
  logic         zr [3];
  logic [W-1:0] res [3];
`ifdef PIPE_ALU_FLAGS_EN
  logic         cy [3];
  logic         ovf [3];
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq [3][$];
  exp_t pend [3];
  exp_t mon_e;
  bit   stalled [3];
  logic [7:0] held_res [3];
  logic held_z [3];
  vec_t tv [11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      pipe_alu #(.WIDTH(W), .DEPTH(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
        .clk(clk),
        .reset(rst_n),
        .in_valid(iv[g]),
        .in_ready(ir[g]),
        .op(op),
        .a(a),
        .b(b),
        .out_valid(ovl[g]),
        .out_ready(orr[g]),
        .result(res[g]),
        .zero(zr[g])
`ifdef PIPE_ALU_FLAGS_EN
        ,
        .carry(cy[g]),
        .overflow(ovf[g])
`endif
      );
    end
  endgenerate

  function automatic int depth_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t mk(logic [7:0] r, logic z, logic c, logic v, bit lat);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference model in integer arithmetic.
  function automatic exp_t model(logic [2:0] o, logic [7:0] aa, logic [7:0] bb, bit lat);
    int ua = aa;
    int ub = bb;
    int sa = $signed(aa);
    int sb = $signed(bb);
    int r = 0;
    int s = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (o)
      3'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << (ub % 8);
      3'd6: r = ua >> (ub % 8);
      default: r = ub;
    endcase
    return mk(r[7:0], (r[7:0] == 8'h00), c, v, lat);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stalled[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (iv[i] && ir[i]) begin
          mon_e = pend[i];
          mon_e.acc = cyc;
          sbq[i].push_back(mon_e);
        end
        if (ovl[i] && orr[i]) begin
          if (sbq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out[%0d]: got result %0h, expected no beat", i, res[i]);
          end else begin
            mon_e = sbq[i].pop_front();
            chk($sformatf("result[%0d]", i), res[i], mon_e.res);
            chk($sformatf("zero[%0d]", i), zr[i], mon_e.z);
`ifdef PIPE_ALU_FLAGS_EN
            chk($sformatf("carry[%0d]", i), cy[i], mon_e.c);
            chk($sformatf("overflow[%0d]", i), ovf[i], mon_e.v);
`endif
            if (mon_e.lat) chk($sformatf("latency[%0d]", i), cyc - mon_e.acc, depth_of(i));
          end
          stalled[i] = 1'b0;
        end else if (ovl[i]) begin
          if (stalled[i]) begin
            chk($sformatf("hold_result[%0d]", i), res[i], held_res[i]);
            chk($sformatf("hold_zero[%0d]", i), zr[i], held_z[i]);
          end
          stalled[i] = 1'b1;
          held_res[i] = res[i];
          held_z[i] = zr[i];
        end else begin
          if (stalled[i]) chk($sformatf("hold_valid[%0d]", i), ovl[i], 1'b1);
          stalled[i] = 1'b0;
        end
      end
    end
  end

  // Entered and left at posedge+#1; back-to-back calls give one beat per cycle.
  task automatic beat(int i, logic [2:0] o, logic [7:0] aa, logic [7:0] bb, exp_t e, bit need_rdy);
    int n = 0;
    op = o; a = aa; b = bb; pend[i] = e; iv[i] = 1'b1;
    @(negedge clk);
    if (need_rdy) chk($sformatf("in_ready[%0d]", i), ir[i], 1'b1);
    while (!ir[i]) begin
      n++;
      if (n > 50) begin
        chk($sformatf("accept_timeout[%0d]", i), n, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic drain(int i);
    int n = 0;
    while (sbq[i].size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("drain[%0d]", i), sbq[i].size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    tv[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{3'b101, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{3'b110, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{3'b111, 8'h12, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[10] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};

    op = '0; a = '0; b = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b1;
      orr[i] = 1'b1;
      pend[i] = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), ovl[i], 1'b0);
      chk($sformatf("rst_result[%0d]", i), res[i], 8'h00);
      chk($sformatf("rst_zero[%0d]", i), zr[i], 1'b0);
      chk($sformatf("rst_in_ready[%0d]", i), ir[i], 1'b1);
`ifdef PIPE_ALU_FLAGS_EN
      chk($sformatf("rst_carry[%0d]", i), cy[i], 1'b0);
      chk($sformatf("rst_overflow[%0d]", i), ovf[i], 1'b0);
`endif
      iv[i] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++)
      beat(1, tv[i].op, tv[i].a, tv[i].b, mk(tv[i].res, tv[i].z, tv[i].c, tv[i].v, 1'b1), 1'b1);
    drain(1);

    // Back-to-back shift stream on every depth.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 6; k++) begin
        logic [7:0] bk;
        bk = k[7:0];
        beat(i, 3'b101, 8'h01, bk, model(3'b101, 8'h01, bk, 1'b1), 1'b1);
      end
      drain(i);
    end

    // Stalled output: pipe fills, in_ready drops, then everything drains in order.
    orr[1] = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic [7:0] bk;
          bk = 8'h11 + k[7:0];
          beat(1, 3'b111, 8'h00, bk, model(3'b111, 8'h00, bk, 1'b0), 1'b0);
        end
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", ir[1], 1'b0);
        chk("stall_out_valid", ovl[1], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        orr[1] = 1'b1;
      end
    join
    drain(1);

    // Reset with two beats in flight and in_valid asserted during reset.
    orr[1] = 1'b0;
    beat(1, 3'b000, 8'h03, 8'h04, model(3'b000, 8'h03, 8'h04, 1'b0), 1'b1);
    beat(1, 3'b000, 8'h05, 8'h06, model(3'b000, 8'h05, 8'h06, 1'b0), 1'b1);
    rst_n = 1'b0;
    iv[1] = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    iv[1] = 1'b0;
    for (int i = 0; i < 3; i++) sbq[i].delete();
    chk("mid_rst_out_valid", ovl[1], 1'b0);
    chk("mid_rst_result", res[1], 8'h00);
    chk("mid_rst_zero", zr[1], 1'b0);
    chk("mid_rst_in_ready", ir[1], 1'b1);
    @(negedge clk);
    chk("post_rst_out_valid", ovl[1], 1'b0);
    orr[1] = 1'b1;
    @(posedge clk);
    #1;
    beat(1, 3'b000, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 Parameter DEPTH, default 2, pipeline register stages between operand capture and result (legal 1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  pipe accepts beat this cycle.
REQ-007 op  input  3  operation select.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B / shift amount.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  WIDTH  registered ALU result.
REQ-013 zero  output  1  registered, high when result is all zeros.

Function
REQ-014 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-015 op encoding: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b, 101 a<<b[S-1:0], 110 a>>b[S-1:0] (logical), 111 pass b; S = clog2(WIDTH).
REQ-016 Add/sub wrap modulo 2^WIDTH; upper b bits ignored for shifts.
REQ-017 Result and zero computed once at capture, carried unchanged through remaining stages.
REQ-018 Each stage holds a valid bit; stage k loads from k-1 when stage k empty or stage k advancing this cycle.
REQ-019 in_ready = !valid[1] || stage 1 advancing; combinational from out_ready permitted.
REQ-020 Latency with out_ready held high: accepted at edge N, out_valid high after edge N+DEPTH-1, i.e. DEPTH cycles.
REQ-021 Throughput: one beat per cycle when out_ready held high; no bubbles inserted.
REQ-022 out_valid high && out_ready low: result, zero, out_valid held stable until accepted.
REQ-023 Pipe full (all DEPTH stages valid) && out_ready low: in_ready low; no beat lost or duplicated.
REQ-024 Simultaneous accept at input and delivery at output on full pipe: both complete same cycle, order preserved.
REQ-025 Beats exit in strict acceptance order.

Reset
REQ-026 reset low at edge: all valid bits 0, result 0, zero 0, in_ready 1 after edge; flags (if compiled) 0.
REQ-027 Reset mid-operation discards all in-flight beats; no out_valid in the cycle following reset release.
REQ-028 in_valid ignored while reset low.

Configuration
REQ-029 Macro PIPE_ALU_FLAGS_EN defined: adds outputs carry (1) and overflow (1), registered and carried with result.
REQ-030 With PIPE_ALU_FLAGS_EN: carry = carry-out of add, borrow (a<b unsigned) of sub, 0 otherwise; overflow = signed overflow of add/sub, 0 otherwise.
REQ-031 Without PIPE_ALU_FLAGS_EN: carry/overflow ports and their registers absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, DEPTH=2, out_ready=1, op=000, a=8'h7F, b=8'h01 -> result 8'h80, zero 0 exactly 2 cycles after accept; overflow 1, carry 0 if flags compiled.
REQ-033 op=001, a=8'h05, b=8'h05 -> result 8'h00, zero 1; op=001, a=8'h00, b=8'h01 -> result 8'hFF, carry 1 with flags.
REQ-034 Stream 6 beats back-to-back (op=101, a=8'h01, b=0..5) with out_ready=1 -> results 8'h01,02,04,08,10,20 on consecutive cycles, in_ready never low.
REQ-035 out_ready=0 while streaming -> in_ready low after DEPTH accepts, result held stable; raise out_ready -> remaining beats delivered in order, none lost or duplicated.
REQ-036 reset low for one cycle with 2 beats in flight -> out_valid 0, result 8'h00, in_ready 1 after edge; first post-reset beat appears DEPTH cycles after accept.
REQ-037 Repeat REQ-034 with DEPTH=1 and DEPTH=4 -> latency 1 and 4 cycles respectively, throughput unchanged.
